// File: rtl/atc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// atc_pkg: shared runway-controller codes, approach codes and FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
package atc_pkg;

  localparam logic [3:0] SIG_RWY_A = 4'b1010;
  localparam logic [3:0] SIG_RWY_B = 4'b1011;
  localparam logic [3:0] SIG_HOLD  = 4'b1101;

  localparam logic [1:0] APP_NORTH = 2'b00;
  localparam logic [1:0] APP_EAST  = 2'b01;
  localparam logic [1:0] APP_SOUTH = 2'b10;
  localparam logic [1:0] APP_WEST  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SAMPLE = 3'd2,
    DECIDE = 3'd3,
    HOLD   = 3'd4
  } state_t;

endpackage : atc_pkg
`default_nettype wire

// File: rtl/req_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// req_fifo: synchronous FIFO with head look-ahead and occupancy count.
// Rev 1.0
// ---------------------------------------------------------------------------
module req_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Guard both ports so a misbehaving caller can never corrupt the pointers.
  assign do_push = push && (count_q != FULL);
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule : req_fifo
`default_nettype wire

// File: rtl/landing_request_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// landing_request_queue: queues landing requests and strobes them to the
// runway controller, turning its response into grant / retry / reject.
// Rev 1.0
// ---------------------------------------------------------------------------
module landing_request_queue
  import atc_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int RETRY_WAIT = 15,
  parameter int MAX_RETRY  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [1:0]             req_dir,
  output logic                   req_ready,
  output logic [1:0]             ctl_d,
  output logic                   ctl_en,
  input  logic [3:0]             ctl_signal,
  output logic                   grant_valid,
  output logic [1:0]             grant_dir,
  output logic                   grant_runway,
  output logic                   reject_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
  localparam int TW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic          ctl_en_q, ctl_en_d;
  logic [1:0]    ctl_d_q, ctl_d_d;
  logic          grant_valid_q, grant_valid_d;
  logic [1:0]    grant_dir_q, grant_dir_d;
  logic          grant_runway_q, grant_runway_d;
  logic          reject_valid_q, reject_valid_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          hold_q, hold_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic          pop;
  logic [1:0]    head;
  logic [CW-1:0] fifo_count;
  logic          granted;

  assign req_ready  = (fifo_count < DEPTH_C);
  assign push       = req_valid && req_ready;
  assign overflow_d = overflow_q | (req_valid & ~req_ready);
  assign granted    = (ctl_signal == SIG_RWY_A) || (ctl_signal == SIG_RWY_B);

  req_fifo #(
    .WIDTH (2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (req_dir),
    .head  (head),
    .count (fifo_count)
  );

  // The response is captured on the edge that enters DECIDE, so the grant or
  // reject pulse and the pop are visible for the whole DECIDE cycle.
  always_comb begin
    state_d        = state_q;
    ctl_en_d       = 1'b0;
    ctl_d_d        = ctl_d_q;
    grant_valid_d  = 1'b0;
    grant_dir_d    = grant_dir_q;
    grant_runway_d = grant_runway_q;
    reject_valid_d = 1'b0;
    tries_d        = tries_q;
    wait_d         = wait_q;
    hold_d         = hold_q;
    pop            = 1'b0;

    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        state_d = DECIDE;
        if (granted) begin
          pop            = 1'b1;
          grant_valid_d  = 1'b1;
          grant_dir_d    = head;
          grant_runway_d = ctl_signal[0];
          tries_d        = '0;
          hold_d         = 1'b0;
        end else if (tries_q == TW'(MAX_RETRY - 1)) begin
          pop            = 1'b1;
          reject_valid_d = 1'b1;
          tries_d        = '0;
          hold_d         = 1'b0;
        end else begin
          tries_d = tries_q + TW'(1);
          wait_d  = WW'(RETRY_WAIT - 1);
          hold_d  = 1'b1;
        end
      end
      DECIDE: begin
        state_d = hold_q ? HOLD : IDLE;
      end
      HOLD: begin
        if (wait_q == '0) begin
          state_d = ISSUE;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobe outputs are registered from the next state to keep them glitch-free.
    if (state_d == ISSUE) begin
      ctl_en_d = 1'b1;
      ctl_d_d  = head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ctl_en_q       <= 1'b0;
      ctl_d_q        <= 2'b00;
      grant_valid_q  <= 1'b0;
      grant_dir_q    <= 2'b00;
      grant_runway_q <= 1'b0;
      reject_valid_q <= 1'b0;
      tries_q        <= '0;
      wait_q         <= '0;
      hold_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctl_en_q       <= ctl_en_d;
      ctl_d_q        <= ctl_d_d;
      grant_valid_q  <= grant_valid_d;
      grant_dir_q    <= grant_dir_d;
      grant_runway_q <= grant_runway_d;
      reject_valid_q <= reject_valid_d;
      tries_q        <= tries_d;
      wait_q         <= wait_d;
      hold_q         <= hold_d;
      overflow_q     <= overflow_d;
    end
  end

  assign ctl_en       = ctl_en_q;
  assign ctl_d        = ctl_d_q;
  assign grant_valid  = grant_valid_q;
  assign grant_dir    = grant_dir_q;
  assign grant_runway = grant_runway_q;
  assign reject_valid = reject_valid_q;
  assign count        = fifo_count;
  assign overflow     = overflow_q;

endmodule : landing_request_queue
`default_nettype wire

// File: tb/tb_landing_request_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_landing_request_queue: directed scenarios plus randomized traffic against
// a timestamp-based queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_landing_request_queue;
  import atc_pkg::*;

  localparam int DEPTH      = 4;
  localparam int RETRY_WAIT = 15;
  localparam int MAX_RETRY  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_dir = 2'b00;
  logic [3:0] ctl_signal = 4'b0000;
  logic       req_ready;
  logic [1:0] ctl_d;
  logic       ctl_en;
  logic       grant_valid;
  logic [1:0] grant_dir;
  logic       grant_runway;
  logic       reject_valid;
  logic [2:0] count;
  logic       overflow;

  int total = 0;
  int bad = 0;

  landing_request_queue #(
    .DEPTH      (DEPTH),
    .RETRY_WAIT (RETRY_WAIT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_dir      (req_dir),
    .req_ready    (req_ready),
    .ctl_d        (ctl_d),
    .ctl_en       (ctl_en),
    .ctl_signal   (ctl_signal),
    .grant_valid  (grant_valid),
    .grant_dir    (grant_dir),
    .grant_runway (grant_runway),
    .reject_valid (reject_valid),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: the queue contents plus absolute edge numbers for the next strobe.
  logic [1:0] mq[$];
  int         m_tries = 0;
  int         m_sched = -1;
  int         m_earliest = 0;
  int         ecnt = 0;
  int         pre;
  logic       m_ctl_en = 1'b0;
  logic [1:0] m_ctl_d = 2'b00;
  logic       m_gv = 1'b0;
  logic [1:0] m_gdir = 2'b00;
  logic       m_grwy = 1'b0;
  logic       m_rv = 1'b0;
  logic       m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_tries    = 0;
      m_sched    = -1;
      m_earliest = 0;
      ecnt       = 0;
      m_ctl_en   = 1'b0;
      m_ctl_d    = 2'b00;
      m_gv       = 1'b0;
      m_gdir     = 2'b00;
      m_grwy     = 1'b0;
      m_rv       = 1'b0;
      m_ovf      = 1'b0;
    end else begin
      pre  = mq.size();
      m_gv = 1'b0;
      m_rv = 1'b0;
      if (m_sched < 0 && ecnt >= m_earliest && pre > 0) m_sched = ecnt;
      m_ctl_en = (m_sched == ecnt);
      if (m_ctl_en) m_ctl_d = mq[0];
      if (m_sched >= 0 && ecnt == m_sched + 2) begin
        if (ctl_signal == 4'b1010 || ctl_signal == 4'b1011) begin
          m_gv   = 1'b1;
          m_gdir = mq[0];
          m_grwy = ctl_signal[0];
          void'(mq.pop_front());
          m_tries    = 0;
          m_sched    = -1;
          m_earliest = ecnt + 2;
        end else begin
          m_tries++;
          if (m_tries == MAX_RETRY) begin
            m_rv = 1'b1;
            void'(mq.pop_front());
            m_tries    = 0;
            m_sched    = -1;
            m_earliest = ecnt + 2;
          end else begin
            m_sched = ecnt + RETRY_WAIT + 1;
          end
        end
      end
      if (req_valid) begin
        if (pre < DEPTH) mq.push_back(req_dir);
        else m_ovf = 1'b1;
      end
      ecnt++;
    end
  end

  always @(negedge clk) begin
    chk("ctl_en", ctl_en, m_ctl_en);
    chk("ctl_d", ctl_d, m_ctl_d);
    chk("grant_valid", grant_valid, m_gv);
    chk("grant_dir", grant_dir, m_gdir);
    chk("grant_runway", grant_runway, m_grwy);
    chk("reject_valid", reject_valid, m_rv);
    chk("count", count, mq.size());
    chk("req_ready", req_ready, (mq.size() < DEPTH) ? 1 : 0);
    chk("overflow", overflow, m_ovf);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  logic [1:0] fill_dirs [5];
  logic [1:0] drain_exp [4];
  int strobes, got, grants, pulses, r;

  initial begin
    fill_dirs = '{APP_NORTH, APP_EAST, APP_SOUTH, APP_WEST, APP_EAST};
    drain_exp = '{APP_NORTH, APP_EAST, APP_SOUTH, APP_WEST};

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_ctl_en", ctl_en, 0);
    chk("rst_ctl_d", ctl_d, 0);
    chk("rst_grant", grant_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_overflow", overflow, 0);

    // Single request granted on runway A.
    ctl_signal = SIG_RWY_A;
    req_valid = 1'b1; req_dir = APP_EAST;
    step();
    req_valid = 1'b0;
    chk("single_count1", count, 1);
    step();
    chk("single_en", ctl_en, 1);
    chk("single_d", ctl_d, 2'b01);
    step();
    chk("single_fall", ctl_en, 0);
    chk("single_dhold", ctl_d, 2'b01);
    step();
    chk("single_grant", grant_valid, 1);
    chk("single_rwy", grant_runway, 0);
    chk("single_dir", grant_dir, 2'b01);
    chk("single_count0", count, 0);
    step();
    chk("single_pulse", grant_valid, 0);
    repeat (3) step();

    // Hold, then granted on runway B after the retry wait.
    ctl_signal = SIG_HOLD;
    req_valid = 1'b1; req_dir = APP_SOUTH;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    chk("hold_nogrant", grant_valid, 0);
    ctl_signal = SIG_RWY_B;
    repeat (15) step();
    chk("hold_wait_en", ctl_en, 0);
    step();
    chk("hold_reissue_en", ctl_en, 1);
    chk("hold_reissue_d", ctl_d, 2'b10);
    repeat (2) step();
    chk("hold_grant", grant_valid, 1);
    chk("hold_rwy", grant_runway, 1);
    chk("hold_dir", grant_dir, 2'b10);
    repeat (3) step();

    // Retry exhaustion with the hold code, then with the unknown code 0000.
    ctl_signal = SIG_HOLD;
    req_valid = 1'b1; req_dir = APP_WEST;
    step();
    req_dir = APP_NORTH;
    step();
    req_valid = 1'b0;
    strobes = int'(ctl_en); got = 0; grants = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      step();
      if (ctl_en) strobes++;
      if (grant_valid) grants++;
      if (reject_valid) got = 1;
    end
    chk("retry1_done", got, 1);
    chk("retry1_strobes", strobes, 3);
    ctl_signal = 4'b0000;
    strobes = 0; got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      step();
      if (ctl_en) strobes++;
      if (grant_valid) grants++;
      if (reject_valid) got = 1;
    end
    chk("retry2_done", got, 1);
    chk("retry2_strobes", strobes, 3);
    chk("retry_nogrant", grants, 0);
    chk("retry_empty", count, 0);
    repeat (3) step();

    // Fill past capacity while the head is held, then drain in order.
    ctl_signal = SIG_HOLD;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_dir = fill_dirs[i];
      step();
    end
    req_valid = 1'b0;
    chk("fill_count", count, 4);
    chk("fill_ready", req_ready, 0);
    chk("fill_overflow", overflow, 1);
    ctl_signal = SIG_RWY_A;
    grants = 0;
    for (int i = 0; i < 400 && grants < 4; i++) begin
      step();
      if (grant_valid) begin
        chk("drain_dir", grant_dir, drain_exp[grants]);
        grants++;
      end
    end
    chk("drain_grants", grants, 4);
    chk("overflow_sticky", overflow, 1);
    repeat (3) step();

    // Reset while the strobe is high.
    ctl_signal = SIG_RWY_A;
    req_valid = 1'b1; req_dir = APP_EAST;
    step();
    req_valid = 1'b0;
    step();
    chk("rstmid_pre_en", ctl_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_en", ctl_en, 0);
    chk("rstmid_d", ctl_d, 0);
    chk("rstmid_count", count, 0);
    chk("rstmid_ready", req_ready, 1);
    chk("rstmid_overflow", overflow, 0);
    chk("rstmid_gdir", grant_dir, 0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant_valid || reject_valid || ctl_en) pulses++;
    end
    chk("rstmid_quiet", pulses, 0);

    // Randomized traffic and controller responses.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_dir   = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 7);
      if (r <= 2)      ctl_signal = SIG_RWY_A;
      else if (r <= 4) ctl_signal = SIG_RWY_B;
      else if (r <= 6) ctl_signal = SIG_HOLD;
      else             ctl_signal = 4'($urandom_range(0, 15));
      step();
    end
    req_valid = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_landing_request_queue
`default_nettype wire
